// File: rtl/count_checker_pkg.sv
// Shared types, default widths and helpers for the counter-stream checker.
package count_checker_pkg;

    // Checker FSM: waiting for a first sample, acquiring lock, locked.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ERR_CNT_W = 16;

    // Increment that sticks at max_val; callers zero-extend narrower values.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val == max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating event counter with synchronous clear.
// A simultaneous clear and increment leaves the count at 1 so the event
// that arrived with the clear is not lost.
module sat_counter
    import count_checker_pkg::*;
#(
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic [ERR_CNT_W-1:0] o_count
);

    localparam logic [31:0] MAX_VAL = 32'({ERR_CNT_W{1'b1}});

    logic [ERR_CNT_W-1:0] r_count;
    logic [ERR_CNT_W-1:0] w_count_inc;

    assign w_count_inc = ERR_CNT_W'(sat_inc(32'(r_count), MAX_VAL));

    // Count register: increment beats clear, clear-with-increment restarts at 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= i_clr ? ERR_CNT_W'(1) : w_count_inc;
        end else if (i_clr) begin
            r_count <= '0;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/count_checker.sv
// Receive-side monitor for a free-running counter stream.
// Acquires lock after LOCK_CYCLES consecutive +1 steps, flags any break in
// the sequence while locked (except a jump to zero, which is read as an
// upstream counter reset), and captures the first bad sample since clear.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ERR_CNT_W   = DEF_ERR_CNT_W,
    parameter int LOCK_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [WIDTH-1:0]     cnt_in,
    input  logic                 cnt_vld,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     exp_cnt,
    output logic [WIDTH-1:0]     bad_cnt,
    output logic [WIDTH-1:0]     bad_exp
);

    // good_run only needs to reach LOCK_CYCLES.
    localparam int                RUN_W      = $clog2(LOCK_CYCLES + 1);
    localparam logic [RUN_W-1:0]  RUN_TARGET = RUN_W'(LOCK_CYCLES);

    state_t             r_state;
    logic [RUN_W-1:0]   r_good_run;
    logic [WIDTH-1:0]   r_exp_cnt;
    logic               r_locked;
    logic               r_err_pulse;
    logic               r_err_sticky;
    logic [WIDTH-1:0]   r_bad_cnt;
    logic [WIDTH-1:0]   r_bad_exp;

    logic               w_match;
    logic [WIDTH-1:0]   w_seed;
    logic [WIDTH-1:0]   w_exp_inc;
    logic [RUN_W-1:0]   w_run_inc;
    logic               w_err_event;
    logic               w_capture;

    assign w_match   = (cnt_in == r_exp_cnt);
    assign w_seed    = cnt_in + 1'b1;
    assign w_exp_inc = r_exp_cnt + 1'b1;
    assign w_run_inc = r_good_run + 1'b1;

    // A break while locked is an error unless the counter restarted at zero.
    assign w_err_event = cnt_vld && (r_state == ST_LOCK) && !w_match
                      && (cnt_in != '0);

    // First error since clear loads the captures; a clear in the same cycle
    // as an error makes this error the new "first".
    assign w_capture = w_err_event && (!r_err_sticky || clr_err);

    // Sequence-tracking FSM; only accepted samples advance it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_good_run <= '0;
            r_exp_cnt  <= '0;
            r_locked   <= 1'b0;
        end else if (cnt_vld) begin
            case (r_state)
                ST_IDLE: begin
                    r_exp_cnt  <= w_seed;
                    r_good_run <= '0;
                    r_state    <= ST_ACQ;
                    r_locked   <= 1'b0;
                end
                ST_ACQ: begin
                    if (w_match) begin
                        r_exp_cnt  <= w_exp_inc;
                        r_good_run <= w_run_inc;
                        if (w_run_inc == RUN_TARGET) begin
                            r_state  <= ST_LOCK;
                            r_locked <= 1'b1;
                        end
                    end else begin
                        // Still hunting: restart the run from this sample.
                        r_exp_cnt  <= w_seed;
                        r_good_run <= '0;
                    end
                end
                ST_LOCK: begin
                    if (w_match) begin
                        r_exp_cnt <= w_exp_inc;
                    end else begin
                        // Both the zero-restart and the error case reseed
                        // from the sample; for zero that yields 1.
                        r_exp_cnt  <= w_seed;
                        r_good_run <= '0;
                        r_state    <= ST_ACQ;
                        r_locked   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_good_run <= '0;
                    r_locked   <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle error strobe; drops on any cycle without an error event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_err_event;
        end
    end

    // Sticky error flag; a new error outranks a coincident clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_sticky <= 1'b0;
        end else if (w_err_event) begin
            r_err_sticky <= 1'b1;
        end else if (clr_err) begin
            r_err_sticky <= 1'b0;
        end
    end

    // First-error capture of the offending sample and what was expected.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bad_cnt <= '0;
            r_bad_exp <= '0;
        end else if (w_capture) begin
            r_bad_cnt <= cnt_in;
            r_bad_exp <= r_exp_cnt;
        end else if (clr_err && !w_err_event) begin
            r_bad_cnt <= '0;
            r_bad_exp <= '0;
        end
    end

    sat_counter #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .i_clr   (clr_err),
        .i_inc   (w_err_event),
        .o_count (err_count)
    );

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;
    assign exp_cnt    = r_exp_cnt;
    assign bad_cnt    = r_bad_cnt;
    assign bad_exp    = r_bad_exp;

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: directed scenarios plus a random
// stream, checked against a sequence-level reference model. Two instances
// share stimulus: default widths, and a 2-bit error counter for saturation.
module tb_count_checker;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] cnt_in;
    logic        cnt_vld;
    logic        clr_err;

    logic        locked, err_pulse, err_sticky;
    logic [15:0] err_count;
    logic [31:0] exp_cnt, bad_cnt, bad_exp;

    logic        locked2, err_pulse2, err_sticky2;
    logic [1:0]  err_count2;
    logic [31:0] exp_cnt2, bad_cnt2, bad_exp2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    count_checker #(.WIDTH(32), .ERR_CNT_W(16), .LOCK_CYCLES(4)) dut (
        .clk(clk), .rstn(rstn), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
        .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse),
        .err_sticky(err_sticky), .err_count(err_count), .exp_cnt(exp_cnt),
        .bad_cnt(bad_cnt), .bad_exp(bad_exp)
    );

    count_checker #(.WIDTH(32), .ERR_CNT_W(2), .LOCK_CYCLES(4)) dut2 (
        .clk(clk), .rstn(rstn), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
        .clr_err(clr_err), .locked(locked2), .err_pulse(err_pulse2),
        .err_sticky(err_sticky2), .err_count(err_count2), .exp_cnt(exp_cnt2),
        .bad_cnt(bad_cnt2), .bad_exp(bad_exp2)
    );

    // ---------------- reference model (sequence level) ----------------
    bit          m_seen;     // any sample since reset
    bit          m_locked;
    int          m_run;      // consecutive +1 steps since last reseed
    logic [31:0] m_exp;
    bit          m_pulse, m_sticky;
    int          m_cnt16, m_cnt2;
    logic [31:0] m_bad_cnt, m_bad_exp;

    function automatic logic [31:0] succ(input logic [31:0] v);
        longint unsigned t;
        t = (longint'(v) + 1) % 64'h1_0000_0000;
        return t[31:0];
    endfunction

    task automatic model_reset();
        m_seen = 0; m_locked = 0; m_run = 0; m_exp = 0;
        m_pulse = 0; m_sticky = 0; m_cnt16 = 0; m_cnt2 = 0;
        m_bad_cnt = 0; m_bad_exp = 0;
    endtask

    task automatic model_update(input logic [31:0] v, input bit vld, input bit clr);
        bit          err;
        logic [31:0] old_exp;
        err = 0;
        old_exp = m_exp;
        if (vld) begin
            if (!m_seen) begin
                m_seen = 1; m_exp = succ(v); m_run = 0;
            end else if (v == m_exp) begin
                m_exp = succ(v);
                if (!m_locked) begin
                    m_run++;
                    if (m_run >= 4) m_locked = 1;
                end
            end else begin
                if (m_locked && v != 0) err = 1;
                m_locked = 0; m_run = 0; m_exp = succ(v);
            end
        end
        m_pulse = err;
        if (err) begin
            if (!m_sticky || clr) begin m_bad_cnt = v; m_bad_exp = old_exp; end
            m_cnt16 = clr ? 1 : (m_cnt16 < 65535 ? m_cnt16 + 1 : 65535);
            m_cnt2  = clr ? 1 : (m_cnt2 < 3 ? m_cnt2 + 1 : 3);
            m_sticky = 1;
        end else if (clr) begin
            m_sticky = 0; m_cnt16 = 0; m_cnt2 = 0; m_bad_cnt = 0; m_bad_exp = 0;
        end
    endtask

    // Drive one cycle (inputs set just after an edge), then advance the model.
    task automatic step(input logic [31:0] v, input bit vld, input bit clr);
        cnt_in = v; cnt_vld = vld; clr_err = clr;
        @(posedge clk); #1;
        model_update(v, vld, clr);
        cnt_vld = 0; clr_err = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 0; cnt_vld = 0; clr_err = 0; cnt_in = 0;
        @(posedge clk); #1;
        rstn = 1;
        model_reset();
    endtask

    task automatic lock_from(input logic [31:0] base);
        for (int i = 0; i < 5; i++) step(base + 32'(i), 1, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if ({locked, err_pulse, err_sticky, err_count, exp_cnt, bad_cnt, bad_exp} !== '0) begin
            bad++; $display("FAIL reset_outputs: got lk=%0b p=%0b s=%0b c=%0d e=%0h b=%0h be=%0h want all 0",
                locked, err_pulse, err_sticky, err_count, exp_cnt, bad_cnt, bad_exp);
        end
    endtask

    task automatic test_lock_acq();
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            step(32'(i), 1, 0);
            total++;
            if (locked !== (i >= 4)) begin
                bad++; $display("FAIL lock_acq[%0d]: locked=%0b want %0b", i, locked, (i >= 4));
            end
        end
        total++;
        if (exp_cnt !== 32'd11 || err_count !== 16'd0) begin
            bad++; $display("FAIL lock_acq_end: exp=%0d cnt=%0d want 11 0", exp_cnt, err_count);
        end
    endtask

    task automatic test_skip_error();
        do_reset();
        for (int i = 0; i <= 5; i++) step(32'(i), 1, 0);
        step(32'd9, 1, 0);
        total++;
        if (err_pulse !== 1'b1 || err_count !== 16'd1 || err_sticky !== 1'b1
            || bad_cnt !== 32'd9 || bad_exp !== 32'd6 || locked !== 1'b0) begin
            bad++; $display("FAIL skip_err: p=%0b c=%0d s=%0b b=%0d be=%0d lk=%0b want 1 1 1 9 6 0",
                err_pulse, err_count, err_sticky, bad_cnt, bad_exp, locked);
        end
        for (int i = 10; i <= 13; i++) begin
            step(32'(i), 1, 0);
            total++;
            if (err_pulse !== 1'b0 || locked !== (i == 13) || err_count !== 16'd1) begin
                bad++; $display("FAIL skip_relock[%0d]: p=%0b lk=%0b c=%0d want 0 %0b 1",
                    i, err_pulse, locked, err_count, (i == 13));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lock_from(32'hFFFF_FFF9);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] v;
            v = 32'hFFFF_FFFE + 32'(i);
            step(v, 1, 0);
            total++;
            if (locked !== 1'b1 || err_pulse !== 1'b0 || exp_cnt !== succ(v)) begin
                bad++; $display("FAIL wrap[%0h]: lk=%0b p=%0b exp=%0h want 1 0 %0h",
                    v, locked, err_pulse, exp_cnt, succ(v));
            end
        end
    endtask

    task automatic test_upstream_reset();
        do_reset();
        lock_from(32'd96);
        total++;
        if (locked !== 1'b1 || exp_cnt !== 32'd101) begin
            bad++; $display("FAIL upr_pre: lk=%0b exp=%0d want 1 101", locked, exp_cnt);
        end
        for (int i = 0; i <= 4; i++) begin
            step(32'(i), 1, 0);
            total++;
            if (locked !== (i == 4) || err_pulse !== 1'b0 || err_count !== 16'd0
                || err_sticky !== 1'b0) begin
                bad++; $display("FAIL upstream_rst[%0d]: lk=%0b p=%0b c=%0d s=%0b want %0b 0 0 0",
                    i, locked, err_pulse, err_count, err_sticky, (i == 4));
            end
        end
    endtask

    task automatic test_saturation_clear();
        logic [31:0] v;
        do_reset();
        lock_from(32'd0);
        for (int e = 0; e < 5; e++) begin
            v = 32'd50 + 32'(10 * e);
            step(v, 1, 0);
            for (int k = 1; k <= 4; k++) step(v + 32'(k), 1, 0);
        end
        total++;
        if (err_count2 !== 2'd3 || err_count !== 16'd5 || bad_cnt2 !== 32'd50
            || bad_exp2 !== 32'd5 || err_sticky2 !== 1'b1) begin
            bad++; $display("FAIL saturate: c2=%0d c16=%0d b=%0d be=%0d s=%0b want 3 5 50 5 1",
                err_count2, err_count, bad_cnt2, bad_exp2, err_sticky2);
        end
        step(32'hDEAD_BEEF, 0, 1);
        total++;
        if (err_count2 !== 2'd0 || err_sticky2 !== 1'b0 || bad_cnt2 !== 32'd0
            || bad_exp2 !== 32'd0 || locked2 !== 1'b1 || exp_cnt2 !== 32'd95) begin
            bad++; $display("FAIL clear_alone: c=%0d s=%0b b=%0d be=%0d lk=%0b exp=%0d want 0 0 0 0 1 95",
                err_count2, err_sticky2, bad_cnt2, bad_exp2, locked2, exp_cnt2);
        end
        step(32'd200, 1, 1);
        total++;
        if (err_count2 !== 2'd1 || err_count !== 16'd1 || err_sticky2 !== 1'b1
            || bad_cnt2 !== 32'd200 || bad_exp2 !== 32'd95 || err_pulse2 !== 1'b1) begin
            bad++; $display("FAIL clear_vs_err: c2=%0d c16=%0d s=%0b b=%0d be=%0d p=%0b want 1 1 1 200 95 1",
                err_count2, err_count, err_sticky2, bad_cnt2, bad_exp2, err_pulse2);
        end
    endtask

    task automatic test_gaps_async_reset();
        do_reset();
        lock_from(32'd1000);
        for (int i = 0; i < 7; i++) begin
            step($urandom, 0, 0);
            total++;
            if (locked !== 1'b1 || exp_cnt !== 32'd1005 || err_pulse !== 1'b0
                || err_count !== 16'd0) begin
                bad++; $display("FAIL gap[%0d]: lk=%0b exp=%0d p=%0b c=%0d want 1 1005 0 0",
                    i, locked, exp_cnt, err_pulse, err_count);
            end
        end
        step(32'd1005, 1, 0);
        total++;
        if (locked !== 1'b1 || exp_cnt !== 32'd1006) begin
            bad++; $display("FAIL gap_resume: lk=%0b exp=%0d want 1 1006", locked, exp_cnt);
        end
        step(32'd7, 1, 0);  // leaves error state behind for the reset to wipe
        #3 rstn = 0;
        #1;
        total++;
        if ({locked, err_pulse, err_sticky, err_count, exp_cnt, bad_cnt, bad_exp,
             err_count2, bad_cnt2} !== '0) begin
            bad++; $display("FAIL async_reset: lk=%0b s=%0b c=%0d exp=%0h b=%0h want all 0",
                locked, err_sticky, err_count, exp_cnt, bad_cnt);
        end
        @(posedge clk); #1;
        rstn = 1;
        model_reset();
        step(32'd42, 1, 0);  // first sample after reset seeds like IDLE
        total++;
        if (exp_cnt !== 32'd43 || locked !== 1'b0 || err_pulse !== 1'b0) begin
            bad++; $display("FAIL post_reset_seed: exp=%0d lk=%0b p=%0b want 43 0 0",
                exp_cnt, locked, err_pulse);
        end
    endtask

    task automatic test_random();
        int          r;
        logic [31:0] v;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      step(m_exp, 1, ($urandom_range(0, 19) == 0));
            else if (r < 78) step($urandom, 1, ($urandom_range(0, 3) == 0));
            else if (r < 82) step(32'd0, 1, 0);
            else if (r < 86) begin v = m_exp + 32'($urandom_range(1, 3)); step(v, 1, 0); end
            else             step($urandom, 0, ($urandom_range(0, 4) == 0));
            total++;
            if (locked !== m_locked || exp_cnt !== m_exp || err_pulse !== m_pulse
                || err_sticky !== m_sticky || err_count !== 16'(m_cnt16)
                || err_count2 !== 2'(m_cnt2) || bad_cnt !== m_bad_cnt
                || bad_exp !== m_bad_exp || locked2 !== m_locked) begin
                bad++; $display("FAIL random[%0d]: lk=%0b exp=%0h p=%0b s=%0b c=%0d c2=%0d b=%0h be=%0h want %0b %0h %0b %0b %0d %0d %0h %0h",
                    n, locked, exp_cnt, err_pulse, err_sticky, err_count, err_count2, bad_cnt, bad_exp,
                    m_locked, m_exp, m_pulse, m_sticky, m_cnt16, m_cnt2, m_bad_cnt, m_bad_exp);
            end
        end
    endtask

    initial begin
        rstn = 0; cnt_in = 0; cnt_vld = 0; clr_err = 0;
        model_reset();
        test_reset();
        test_lock_acq();
        test_skip_error();
        test_wrap();
        test_upstream_reset();
        test_saturation_clear();
        test_gaps_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
